// File: rtl/mod_exp_param.sv
// rtl/mod_exp_param.sv - Montgomery modular exponentiation engine; MOD_EXP_CONST_TIME_EN selects constant-time exponent scan
module mod_exp_param #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           len,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     r2,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result
);

  localparam int EIW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0]     ONE   = WIDTH'(1);
  localparam logic [EXP_WIDTH-1:0] ONE_E = EXP_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRE_B,
    PRE_X,
    SQR,
    MUL,
    POST,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  // Operands captured on accept
  logic [7:0]           len_r;
  logic [WIDTH-1:0]     base_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [WIDTH-1:0]     mod_r;
  logic [WIDTH-1:0]     r2_r;

  // Montgomery-domain base and running value
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     x_r;

  // Shared multiplier state; two extra bits keep T < 4N without overflow
  logic [WIDTH+1:0]     mm_t;
  logic [7:0]           mm_cnt;
  logic [EIW-1:0]       exp_idx;

  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 a_bit;
  logic                 exp_bit;
  logic                 idx_zero;
  logic                 mm_last;
  logic                 param_err;
  logic [WIDTH+1:0]     t_add;
  logic [WIDTH+1:0]     t_sum;
  logic [WIDTH+1:0]     t_iter;
  logic                 t_ge;
  logic [WIDTH-1:0]     prod;

  assign param_err = ~modulus[0] | (len == 8'd0) | (int'(len) > WIDTH);
  assign mm_last   = (mm_cnt == len_r);
  assign idx_zero  = (exp_idx == '0);
  assign exp_bit   = |(exp_r & (ONE_E << exp_idx));
  assign a_bit     = |(op_a & (ONE << mm_cnt));

  // One radix-2 step: add a_i*b, make even by adding N, halve
  assign t_add  = mm_t + (a_bit ? {2'b00, op_b} : '0);
  assign t_sum  = t_add + (t_add[0] ? {2'b00, mod_r} : '0);
  assign t_iter = t_sum >> 1;

  // Final conditional subtract; the result is below N so the low WIDTH bits suffice
  assign t_ge = (mm_t >= {2'b00, mod_r});
  assign prod = mm_t[WIDTH-1:0] - (t_ge ? mod_r : '0);

  // Route the multiplier operands according to the current phase
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      PRE_B: begin
        op_a = base_r;
        op_b = r2_r;
      end
      PRE_X: begin
        op_a = ONE;
        op_b = r2_r;
      end
      SQR: begin
        op_a = x_r;
        op_b = x_r;
      end
      MUL: begin
        op_a = x_r;
        op_b = b_r;
      end
      POST: begin
        op_a = x_r;
        op_b = ONE;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and status outputs; each MM phase advances only on its final-subtract cycle
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = param_err ? DONE : PRE_B;
        end
      end
      PRE_B: begin
        busy = 1'b1;
        if (mm_last) state_n = PRE_X;
      end
      PRE_X: begin
        busy = 1'b1;
        if (mm_last) state_n = SQR;
      end
      SQR: begin
        busy = 1'b1;
        if (mm_last) begin
`ifdef MOD_EXP_CONST_TIME_EN
          state_n = MUL;
`else
          if (exp_bit) begin
            state_n = MUL;
          end else if (idx_zero) begin
            state_n = POST;
          end else begin
            state_n = SQR;
          end
`endif
        end
      end
      MUL: begin
        busy = 1'b1;
        if (mm_last) state_n = idx_zero ? POST : SQR;
      end
      POST: begin
        busy = 1'b1;
        if (mm_last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Operand capture, multiplier accumulator and result write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r   <= '0;
      base_r  <= '0;
      exp_r   <= '0;
      mod_r   <= '0;
      r2_r    <= '0;
      b_r     <= '0;
      x_r     <= '0;
      mm_t    <= '0;
      mm_cnt  <= '0;
      exp_idx <= '0;
      err     <= 1'b0;
      result  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        if (param_err) begin
          err    <= 1'b1;
          result <= '0;
        end else begin
          err     <= 1'b0;
          len_r   <= len;
          base_r  <= base;
          exp_r   <= exponent;
          mod_r   <= modulus;
          r2_r    <= r2;
          mm_t    <= '0;
          mm_cnt  <= '0;
          exp_idx <= EIW'(EXP_WIDTH - 1);
        end
      end
    end else if (state != DONE) begin
      if (!mm_last) begin
        mm_t   <= t_iter;
        mm_cnt <= mm_cnt + 8'd1;
      end else begin
        mm_t   <= '0;
        mm_cnt <= '0;
        case (state)
          PRE_B: b_r <= prod;
          PRE_X: x_r <= prod;
          SQR: begin
            x_r <= prod;
            if (state_n == SQR) exp_idx <= exp_idx - EIW'(1);
          end
          MUL: begin
            // A zero bit in constant-time mode still runs MUL but keeps X
            if (exp_bit) x_r <= prod;
            if (!idx_zero) exp_idx <= exp_idx - EIW'(1);
          end
          POST: result <= prod;
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mod_exp_param.md
MOD_EXP_PARAM -- requirements
Module: mod_exp_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving modulus/operand/result width in bits.
REQ-002 SHALL have parameter EXP_WIDTH, default 32, giving exponent width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port len  input  8  modulus bit length L; Montgomery R = 2^L.
REQ-007 SHALL have port base  input  WIDTH  base, caller guarantees base < modulus.
REQ-008 SHALL have port exponent  input  EXP_WIDTH  exponent.
REQ-009 SHALL have port modulus  input  WIDTH  odd modulus N.
REQ-010 SHALL have port r2  input  WIDTH  R^2 mod N, host-precomputed.
REQ-011 SHALL have port busy  output  1  high from accept until done.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  valid with done; parameter error.
REQ-014 SHALL have port result  output  WIDTH  base^exponent mod N, held until next accept.

Function
REQ-015 SHALL register len, base, exponent, modulus, r2 on accept (start=1 in IDLE); later input changes have no effect.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL flag err when modulus[0]=0, len=0, or len>WIDTH: done=1, err=1, result=0 on the cycle after accept; no multiplication.
REQ-018 SHALL contain one radix-2 Montgomery multiplier MM(a,b) = a*b*R^-1 mod N: L iteration cycles (T += a_i*b; if T odd T += N; T >>= 1), then 1 final-subtract cycle (T>=N -> T-N); L+1 cycles per MM; accumulator WIDTH+2 bits, no overflow.
REQ-019 SHALL use FSM states IDLE, PRE_B, PRE_X, SQR, MUL, POST, DONE.
REQ-020 SHALL perform PRE_B: B = MM(base, r2); then PRE_X: X = MM(1, r2).
REQ-021 SHALL scan exponent from bit EXP_WIDTH-1 down to 0: SQR X = MM(X,X); if bit=1, MUL X = MM(X,B); after bit 0 go to POST.
REQ-022 SHALL perform POST: result = MM(X,1), then DONE asserts done for exactly one cycle and returns to IDLE.
REQ-023 SHALL give latency accept-to-done of 1 + (3 + EXP_WIDTH + popcount(exponent)) * (L+1) cycles.
REQ-024 SHALL return result=1 for exponent=0 with N>1, and result=0 for N=1.
REQ-025 SHALL allow a new start in the cycle after done (back-to-back).

Reset
REQ-026 SHALL, with rst=1 at a clock edge, force FSM to IDLE, busy=0, done=0, err=0, result=0, clear all internal registers.
REQ-027 SHALL abort any operation in progress when reset mid-operation, with no done pulse; start is ignored while rst=1.

Configuration
REQ-028 SHALL support macro MOD_EXP_CONST_TIME_EN.
REQ-029 SHALL, when MOD_EXP_CONST_TIME_EN is defined, execute MUL for every exponent bit, discarding the product when the bit is 0 (X unchanged); latency = 1 + (3 + 2*EXP_WIDTH)*(L+1), independent of exponent.
REQ-030 SHALL, when MOD_EXP_CONST_TIME_EN is undefined, skip MUL for 0 bits per REQ-021/REQ-023.

Verification (WIDTH=32, EXP_WIDTH=32)
REQ-031 SHALL cover: N=13, L=4, r2=9, base=4, exp=13 -> result=4, err=0; done 191 cycles after accept (336 with MOD_EXP_CONST_TIME_EN).
REQ-032 SHALL cover: N=3233, L=12, r2=1179, base=65, exp=17 -> result=2790.
REQ-033 SHALL cover: N=13, L=4, r2=9, base=3, exp=0 -> result=1; N=1, L=1, r2=0, base=0, exp=5 -> result=0.
REQ-034 SHALL cover: modulus=12 (even) -> done=1, err=1, result=0 one cycle after accept; len=40 -> same.
REQ-035 SHALL cover: start pulsed mid-operation with different base -> ignored, first result unchanged; rst pulsed during SQR -> next cycle busy=0, done=0, result=0, no done pulse; following start completes correctly.
